// File: rtl/vga_pkg.sv
// Default 800x600 timing shared by the sync generator and the pixel renderer,
// plus the output pipeline depth the renderer's BRAM + output register imply.
package vga_pkg;

  localparam int CNT_W       = 11;
  localparam int FRAME_CNT_W = 8;

  localparam int DEF_H_VIS  = 800;
  localparam int DEF_H_FP   = 56;
  localparam int DEF_H_SYNC = 120;
  localparam int DEF_H_BP   = 64;
  localparam int DEF_V_VIS  = 600;
  localparam int DEF_V_FP   = 37;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP   = 23;

  localparam int DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_PIPE_DLY = 2;

  // Half-open window test lo <= cnt < hi on counter-width values.
  function automatic logic in_span(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Width x depth shift register with a per-bit reset value; depth 0 is a wire.
module sync_delay_line #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst_n;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: undelayed enables/strobes for the renderer, and
// sync/blanking pins delayed to line up with the renderer's registered RGB.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_VIS    = DEF_H_VIS,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_VIS    = DEF_V_VIS,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic                   pclk,
  input  logic                   rstn,
  output logic                   hen,
  output logic                   ven,
  output logic                   hs,
  output logic                   vs,
  output logic                   de_out,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   vblank_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] L_H_VIS  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] L_V_VIS  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] L_HS_BEG = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] L_HS_END = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] L_VS_BEG = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] L_VS_END = CNT_W'(V_VIS + V_FP + V_SYNC);

  // r_run holds the counters for one cycle after reset so that the first
  // visible pixel lands on the second edge after release.
  logic                   r_run;
  logic [CNT_W-1:0]       r_hcnt;
  logic [CNT_W-1:0]       r_vcnt;

  logic                   r_hen;
  logic                   r_ven;
  logic                   r_hs_raw;
  logic                   r_vs_raw;
  logic                   r_line_start;
  logic                   r_frame_start;
  logic                   r_vblank_start;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic                   w_h_last;
  logic                   w_v_last;
  logic                   w_hen;
  logic                   w_ven;
  logic                   w_hs_raw;
  logic                   w_vs_raw;
  logic                   w_line_start;
  logic                   w_frame_start;
  logic                   w_vblank_start;
  logic                   w_de_raw;
  logic [2:0]             w_dly_q;

  assign w_h_last = (r_hcnt == L_H_LAST);
  assign w_v_last = (r_vcnt == L_V_LAST);

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_run  <= 1'b0;
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_h_last) begin
          r_hcnt <= '0;
          r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end
  end

  assign w_hen          = (r_hcnt < L_H_VIS);
  assign w_ven          = (r_vcnt < L_V_VIS);
  assign w_hs_raw       = in_span(r_hcnt, L_HS_BEG, L_HS_END) ? HS_POL : ~HS_POL;
  assign w_vs_raw       = in_span(r_vcnt, L_VS_BEG, L_VS_END) ? VS_POL : ~VS_POL;
  assign w_line_start   = (r_hcnt == '0) && w_ven;
  assign w_frame_start  = (r_hcnt == '0) && (r_vcnt == '0);
  assign w_vblank_start = (r_hcnt == '0) && (r_vcnt == L_V_VIS);

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_hen          <= 1'b0;
      r_ven          <= 1'b0;
      r_hs_raw       <= ~HS_POL;
      r_vs_raw       <= ~VS_POL;
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      if (r_run) begin
        r_hen          <= w_hen;
        r_ven          <= w_ven;
        r_hs_raw       <= w_hs_raw;
        r_vs_raw       <= w_vs_raw;
        r_line_start   <= w_line_start;
        r_frame_start  <= w_frame_start;
        r_vblank_start <= w_vblank_start;
      end
      if (r_vblank_start) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign w_de_raw = r_hen & r_ven;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_sync_dly (
    .i_clk   (pclk),
    .i_rst_n (rstn),
    .i_d     ({r_hs_raw, r_vs_raw, w_de_raw}),
    .o_q     (w_dly_q)
  );

  assign hs           = w_dly_q[2];
  assign vs           = w_dly_q[1];
  assign de_out       = w_dly_q[0];
  assign hen          = r_hen;
  assign ven          = r_ven;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
  assign vblank_start = r_vblank_start;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: one full-size instance plus four short-timing variants
// (delay 2/0/7, inverted polarity) compared every cycle against a raster model.
module tb_vga_sync_gen;

  typedef struct {
    int   hvis, hfp, hsync, hbp;
    int   vvis, vfp, vsync, vbp;
    logic hpol, vpol;
    int   dly;
  } tparam_t;

  logic pclk = 1'b0;
  logic rstn;
  always #5 pclk = ~pclk;

  logic [4:0] hen, ven, hs, vs, de, ls, fs, vb;
  logic [7:0] fc [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam bit SHORT = (g != 0);
    vga_sync_gen #(
      .H_VIS    (SHORT ? 8 : 800),
      .H_FP     (SHORT ? 2 : 56),
      .H_SYNC   (SHORT ? 2 : 120),
      .H_BP     (SHORT ? 2 : 64),
      .V_VIS    (SHORT ? 4 : 600),
      .V_FP     (SHORT ? 1 : 37),
      .V_SYNC   (SHORT ? 1 : 6),
      .V_BP     (SHORT ? 1 : 23),
      .HS_POL   ((g == 4) ? 1'b0 : 1'b1),
      .VS_POL   ((g == 4) ? 1'b0 : 1'b1),
      .PIPE_DLY ((g == 2) ? 0 : ((g == 3) ? 7 : 2))
    ) u_dut (
      .pclk         (pclk),
      .rstn         (rstn),
      .hen          (hen[g]),
      .ven          (ven[g]),
      .hs           (hs[g]),
      .vs           (vs[g]),
      .de_out       (de[g]),
      .line_start   (ls[g]),
      .frame_start  (fs[g]),
      .vblank_start (vb[g]),
      .frame_cnt    (fc[g])
    );
  end

  int      total = 0;
  int      bad   = 0;
  int      t     = 0;
  int      phase = 0;
  int      hs_rise[$];
  int      hs_fall[$];
  logic    prev_hs;
  int      cnt_de, cnt_ls, cnt_fs, cnt_vb;
  tparam_t P [5];

  task automatic chk(input string tag, input int idx, input int tc,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] t=%0d observed=%0h expected=%0h", tag, idx, tc, obs, exp);
    end
  endtask

  // {hs,vs,de} as registered before the delay line, s edges after release.
  function automatic logic [2:0] raw_at(input int s, input tparam_t p);
    int htot, vtot, k, hc, vc;
    logic h, v, d;
    if (s < 2) return {~p.hpol, ~p.vpol, 1'b0};
    htot = p.hvis + p.hfp + p.hsync + p.hbp;
    vtot = p.vvis + p.vfp + p.vsync + p.vbp;
    k  = s - 2;
    hc = k % htot;
    vc = (k / htot) % vtot;
    h = (hc >= p.hvis + p.hfp && hc < p.hvis + p.hfp + p.hsync) ? p.hpol : ~p.hpol;
    v = (vc >= p.vvis + p.vfp && vc < p.vvis + p.vfp + p.vsync) ? p.vpol : ~p.vpol;
    d = (hc < p.hvis) && (vc < p.vvis);
    return {h, v, d};
  endfunction

  function automatic logic [15:0] expect_at(input int tc, input tparam_t p);
    int htot, vtot, fr, vbk, k, hc, vc, n;
    logic [2:0] dl;
    logic he, ve, l, f, b;
    logic [7:0] c;
    htot = p.hvis + p.hfp + p.hsync + p.hbp;
    vtot = p.vvis + p.vfp + p.vsync + p.vbp;
    fr   = htot * vtot;
    vbk  = p.vvis * htot;
    dl   = raw_at(tc - p.dly, p);
    he = 1'b0; ve = 1'b0; l = 1'b0; f = 1'b0; b = 1'b0;
    if (tc >= 2) begin
      k  = tc - 2;
      hc = k % htot;
      vc = (k / htot) % vtot;
      he = (hc < p.hvis);
      ve = (vc < p.vvis);
      l  = (hc == 0) && (vc < p.vvis);
      f  = (k % fr) == 0;
      b  = (k % fr) == vbk;
    end
    n = tc - 3;
    c = (n < vbk) ? 8'd0 : 8'((n - vbk) / fr + 1);
    return {he, ve, dl[2], dl[1], dl[0], l, f, b, c};
  endfunction

  function automatic logic [15:0] obs(input int i);
    return {hen[i], ven[i], hs[i], vs[i], de[i], ls[i], fs[i], vb[i], fc[i]};
  endfunction

  task automatic step();
    @(posedge pclk);
    t++;
    @(negedge pclk);
    for (int i = 0; i < 5; i++) chk("vec", i, t, 32'(obs(i)), 32'(expect_at(t, P[i])));
    if (phase == 1) begin
      if (t == 1) chk("hen_early", 0, t, 32'(hen[0]), 32'd0);
      if (t == 2) chk("first_pix", 0, t, 32'({hen[0], ven[0], fs[0], ls[0]}), 32'hF);
      if (hs[0] && !prev_hs) hs_rise.push_back(t);
      if (!hs[0] && prev_hs) hs_fall.push_back(t);
      prev_hs = hs[0];
    end
    if (phase == 2) begin
      if (t >= 2 && t < 100) begin
        cnt_de += int'(hen[1] & ven[1]);
        cnt_ls += int'(ls[1]);
        cnt_fs += int'(fs[1]);
        cnt_vb += int'(vb[1]);
      end
      if (t == 2) chk("restart_fs", 0, t, 32'({fs[0], hen[0]}), 32'd3);
      if (t == 25048) chk("fc_pre_wrap", 1, t, 32'(fc[1]), 32'd255);
      if (t == 25049) chk("fc_wrap", 1, t, 32'(fc[1]), 32'd0);
    end
  endtask

  initial begin
    P[0] = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, 2};
    P[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2};
    P[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0};
    P[3] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 7};
    P[4] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 2};

    rstn = 1'b0;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 5; i++) chk("rst_vec", i, 0, 32'(obs(i)), 32'(expect_at(0, P[i])));
    chk("rst_pol0", 4, 0, 32'({hs[4], vs[4]}), 32'd3);

    rstn    = 1'b1;
    t       = 0;
    phase   = 1;
    prev_hs = hs[0];
    repeat (2491) step();

    chk("hs_rises", 0, t, 32'(hs_rise.size()), 32'd2);
    chk("hs_falls", 0, t, 32'(hs_fall.size()), 32'd2);
    if (hs_rise.size() >= 2 && hs_fall.size() >= 1) begin
      chk("hs_phase",  0, t, 32'(hs_rise[0] - 2), 32'd858);
      chk("hs_period", 0, t, 32'(hs_rise[1] - hs_rise[0]), 32'd1040);
      chk("hs_width",  0, t, 32'(hs_fall[0] - hs_rise[0]), 32'd120);
    end

    // Mid-line reset: default instance at hcnt 409, short ones with hs active in-flight.
    phase = 3;
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) chk("async_rst", i, t, 32'(obs(i)), 32'(expect_at(0, P[i])));
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int i = 0; i < 5; i++) chk("rst_hold", i, t, 32'(obs(i)), 32'(expect_at(0, P[i])));

    rstn   = 1'b1;
    t      = 0;
    phase  = 2;
    cnt_de = 0;
    cnt_ls = 0;
    cnt_fs = 0;
    cnt_vb = 0;
    repeat (25100) step();

    chk("frame_de", 1, t, 32'(cnt_de), 32'd32);
    chk("frame_ls", 1, t, 32'(cnt_ls), 32'd4);
    chk("frame_fs", 1, t, 32'(cnt_fs), 32'd1);
    chk("frame_vb", 1, t, 32'(cnt_vb), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
